adc_read_ad7476: RTL and testbench

Serial ADC reader for a 12-bit AD7476-class converter on the UCD custom I/O header; the receive-side counterpart of the AD5626 DAC writer. On a one-cycle `conv` strobe (the shared sample-rate strobe) it drives CS and SCLK, shifts in one 16-bit frame on SDATA, and presents the 12-bit sample with a one-cycle `valid` pulse. It sits between the header pins and the FIR input, replacing the XADC path when the external converter is used.

---
 rtl/adc_read_ad7476.sv | 185 ++++++++++++++++++
 tb/tb_adc_read_ad7476.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_read_ad7476.sv
// ---------------------------------------------------------------------------
// adc_read_ad7476
//
// Serial reader for a 12-bit AD7476-class ADC on the custom I/O header.
// A one-cycle conv strobe starts one 16-bit frame. The reader drives CS and
// SCLK and samples SDATA on each SCLK rising edge. It then presents the
// 12-bit sample together with a one-cycle valid pulse.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (>= 2)
//   QUIET    clk cycles CS stays high after a frame before the next conv
//            can be accepted (>= 1)
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   conv       start-conversion strobe, honoured only while busy is low
//   sdata      serial data from the ADC (registered once internally)
//   cs         chip select to the ADC, active low (registered)
//   sclk       serial clock to the ADC, idles high (registered)
//   data       last received sample, held until the next frame completes
//   valid      one-cycle pulse when data updates
//   busy       high from the cycle after conv is accepted until quiet ends
//   frame_err  leading-zero check result
//
// Build option:
//   ADC_READ_FRAME_CHECK_EN  when defined, frame_err is set at the end of
//                            each frame to the OR of the four leading bits.
//                            When undefined, frame_err is tied low.
// ---------------------------------------------------------------------------
module adc_read_ad7476 #(
    parameter int unsigned CLK_DIV = 5,
    parameter int unsigned QUIET   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        conv,
    input  logic        sdata,
    output logic        cs,
    output logic        sclk,
    output logic [11:0] data,
    output logic        valid,
    output logic        busy,
    output logic        frame_err
);

    // A single counter serves both the SCLK half-period and the quiet time.
    localparam int unsigned CNT_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_TC   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_TC = CNT_W'(QUIET - 1);

    // Without the frame check, the leading four bits are never looked at.
    // Only the last 12 shifted bits need to be kept.
`ifdef ADC_READ_FRAME_CHECK_EN
    localparam int unsigned SHIFT_W = 16;
`else
    localparam int unsigned SHIFT_W = 12;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_QUIET
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         bit_q;
    logic               sdata_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_d;
    logic               cs_q;
    logic               sclk_q;
    logic [11:0]        data_q;
    logic               valid_q;
    logic               busy_q;
`ifdef ADC_READ_FRAME_CHECK_EN
    logic               ferr_q;
`endif

    assign shift_d = {shift_q[SHIFT_W-2:0], sdata_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sdata_q <= 1'b0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ADC_READ_FRAME_CHECK_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            sdata_q <= sdata;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (conv) begin
                        state_q <= S_SETUP;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end

                // CS setup time. The first SCLK falling edge ends this phase.
                S_SETUP: begin
                    if (cnt_q == DIV_TC) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b0;
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // Sample on the low-to-high toggle. The registered sdata is
                // the value the ADC has held for CLK_DIV-1 cycles since the
                // falling edge.
                S_SHIFT: begin
                    if (cnt_q == DIV_TC) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            shift_q <= shift_d;
                            bit_q   <= bit_q + 4'd1;
                            if (bit_q == 4'd15) begin
                                state_q <= S_DONE;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    cs_q    <= 1'b1;
                    sclk_q  <= 1'b1;
                    data_q  <= shift_q[11:0];
                    valid_q <= 1'b1;
`ifdef ADC_READ_FRAME_CHECK_EN
                    ferr_q  <= |shift_q[15:12];
`endif
                    cnt_q   <= '0;
                    state_q <= S_QUIET;
                end

                S_QUIET: begin
                    if (cnt_q == QUIET_TC) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cs    = cs_q;
    assign sclk  = sclk_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;
`ifdef ADC_READ_FRAME_CHECK_EN
    assign frame_err = ferr_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_read_ad7476.sv
// ---------------------------------------------------------------------------
// tb_adc_read_ad7476
//
// Directed bench for adc_read_ad7476 at CLK_DIV=5 and QUIET=5.
// An ADC model shifts out a loaded 16-bit frame MSB first on SCLK falling
// edges. Each accepted conversion pushes its expected sample, frame_err and
// valid cycle onto a scoreboard. A monitor pops the scoreboard on every
// valid pulse and compares. A second monitor checks the SCLK waveform shape.
//
// Cycle numbering: a conversion's cycle 0 is the clock edge that samples
// conv. The value "at cycle n" is the one present when edge n samples it.
// That value is observed on the falling clock edge before edge n.
// ---------------------------------------------------------------------------
module tb_adc_read_ad7476;

    localparam int unsigned DIV   = 5;
    localparam int unsigned QT    = 5;
    localparam int unsigned T_VAL = 2 + 32 * DIV;       // 162
    localparam int unsigned T_BSY = 2 + 32 * DIV + QT;  // 167

    logic        clk = 1'b0;
    logic        rst;
    logic        conv;
    logic        sdata;
    logic        cs;
    logic        sclk;
    logic [11:0] data;
    logic        valid;
    logic        busy;
    logic        frame_err;

    adc_read_ad7476 #(.CLK_DIV(DIV), .QUIET(QT)) dut (
        .clk       (clk),
        .rst       (rst),
        .conv      (conv),
        .sdata     (sdata),
        .cs        (cs),
        .sclk      (sclk),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // edge_n = number of rising edges so far = index of the next edge
    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ferr(input logic [15:0] f);
`ifdef ADC_READ_FRAME_CHECK_EN
        return |f[15:12];
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- ADC model ----------------
    logic [15:0] adc_frame = '0;
    int          bit_idx   = 15;

    always @(negedge cs) bit_idx = 15;

    always @(negedge sclk) begin
        if (cs === 1'b0) begin
            if (bit_idx >= 0) sdata = adc_frame[bit_idx];
            bit_idx = bit_idx - 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [11:0] data;
        logic        ferr;
        int unsigned at;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            check("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data", 32'(data), 32'(e.data));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
                check("valid_cycle", edge_n, e.at);
            end
        end
    end

    // ---------------- SCLK shape monitor ----------------
    int   mon_rises   = 0;
    int   mon_phases  = 0;
    int   mon_bad     = 0;
    int   mon_cs_bad  = 0;
    int   run_len     = 0;
    bit   started     = 1'b0;
    logic prev_sclk   = 1'b1;
    logic prev_cs     = 1'b1;

    always @(negedge clk) begin
        if (cs === 1'b1 && sclk !== 1'b1) mon_cs_bad++;
        if (prev_cs === 1'b1 && cs === 1'b0) begin
            started = 1'b1;
            run_len = 1;
        end else if (cs !== 1'b0) begin
            started = 1'b0;
        end else if (sclk !== prev_sclk) begin
            if (started) begin
                mon_phases++;
                if (run_len != DIV) mon_bad++;
                if (sclk === 1'b1) mon_rises++;
            end
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_sclk = sclk;
        prev_cs   = cs;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_conv(output int unsigned t);
        conv = 1'b1;
        t    = edge_n;
        step();
        conv = 1'b0;
    endtask

    task automatic wait_rel(input int unsigned t, input int unsigned c);
        while (edge_n < t + c) step();
    endtask

    task automatic push_exp(input logic [15:0] f, input int unsigned t);
        exp_t e;
        e.data = f[11:0];
        e.ferr = exp_ferr(f);
        e.at   = t + T_VAL;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_frame(input logic [15:0] f);
        int unsigned t;
        adc_frame = f;
        start_conv(t);
        push_exp(f, t);
        wait_rel(t, T_BSY - 1);
        check("busy_before_quiet_end", 32'(busy), 32'd1);
        step();
        check("busy_quiet_end", 32'(busy), 32'd0);
        check("data_held", 32'(data), 32'(f[11:0]));
        check("ferr_held", 32'(frame_err), 32'(exp_ferr(f)));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int unsigned t;
        int unsigned t2;

        rst   = 1'b1;
        conv  = 1'b0;
        sdata = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // reset state
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);

        // basic read plus SCLK shape
        mon_rises = 0; mon_phases = 0; mon_bad = 0; mon_cs_bad = 0;
        adc_frame = 16'h0A5C;
        start_conv(t);
        push_exp(16'h0A5C, t);
        check("c1_cs_low", 32'(cs), 32'd0);
        check("c1_busy", 32'(busy), 32'd1);
        wait_rel(t, DIV);
        check("setup_sclk_high", 32'(sclk), 32'd1);
        step();
        check("first_fall", 32'(sclk), 32'd0);
        wait_rel(t, T_VAL - 1);
        check("cs_low_last_bit", 32'(cs), 32'd0);
        step();
        check("cs_high_done", 32'(cs), 32'd1);
        wait_rel(t, T_BSY - 1);
        check("busy_166", 32'(busy), 32'd1);
        step();
        check("busy_167", 32'(busy), 32'd0);
        wait_rel(t, T_BSY + 3);
        check("sclk_rises", 32'(mon_rises), 32'd16);
        check("sclk_phases", 32'(mon_phases), 32'd32);
        check("sclk_phase_len", 32'(mon_bad), 32'd0);
        check("sclk_high_cs_high", 32'(mon_cs_bad), 32'd0);
        drain();

        // extremes
        run_frame(16'h0FFF);
        run_frame(16'h0000);

        // back-to-back: the strobe at 50 is dropped, the one at 167 accepted
        adc_frame = 16'h0321;
        start_conv(t);
        push_exp(16'h0321, t);
        wait_rel(t, 50);
        conv = 1'b1;
        step();
        conv = 1'b0;
        check("b2b_busy_51", 32'(busy), 32'd1);
        wait_rel(t, T_VAL + 1);
        adc_frame = 16'h0456;
        wait_rel(t, T_BSY);
        start_conv(t2);
        check("b2b_accepted", 32'(busy), 32'd1);
        push_exp(16'h0456, t2);
        wait_rel(t2, T_BSY);
        drain();

        // frame check
        run_frame(16'h8123);
        run_frame(16'h0123);
        run_frame(16'h4ABC);

        // reset mid-frame: no valid, then a clean frame after
        adc_frame = 16'h0DEF;
        start_conv(t);
        wait_rel(t, 80);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(data), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_ferr", 32'(frame_err), 32'd0);
        wait_rel(t, 90);
        adc_frame = 16'h0789;
        start_conv(t2);
        push_exp(16'h0789, t2);
        wait_rel(t2, T_BSY);
        drain();

        // conv together with rst: reset wins and conv is not queued
        conv = 1'b1;
        rst  = 1'b1;
        step();
        conv = 1'b0;
        rst  = 1'b0;
        check("convrst_busy", 32'(busy), 32'd0);
        check("convrst_cs", 32'(cs), 32'd1);
        repeat (3) step();
        check("convrst_not_queued", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
